mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the pipelined MIPS core. It sits beside the E-stage ALU and accepts mult/multu/div/divu/mthi/mtlo from E. It sequences a fixed-latency busy window, owns the HI/LO registers, and drives the D-stage stall request so that no MD instruction issues while a previous operation is in flight. It is a shared resource arbitrated in time by stalling, not by queueing.

---
 rtl/mdu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the E stage of the pipelined core.
// It accepts mult/multu/div/divu and mthi/mtlo, runs a fixed-latency busy window,
// owns HI/LO, and asks the D stage to stall while an MD op is in flight.
//
// Ports:
//   clk    in   1   core clock, rising edge
//   reset  in   1   asynchronous active-high reset, clears all state
//   start  in   1   MD arithmetic op valid in E this cycle
//   op     in   2   0=mult 1=multu 2=div 3=divu, sampled with start
//   a, b   in  32   rs / rt operands
//   mthi   in   1   write wdata to HI
//   mtlo   in   1   write wdata to LO
//   wdata  in  32   data for mthi/mtlo
//   md_d   in   1   D-stage instruction is an MD-class op
//   busy   out  1   operation in flight
//   stall  out  1   freeze PC/F/D, bubble into E
//   done   out  1   one-cycle pulse in the cycle after HI/LO commit
//   hi, lo out 32   HI / LO registers
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [31:0]       wdata,
    input  logic              md_d,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [31:0]       hi,
    output logic [31:0]       lo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result of an MD op as {commit_ok, hi, lo}. Signed divide works on
    // magnitudes and fixes signs afterwards, so 0x80000000 / -1 yields
    // 0x80000000 remainder 0 without relying on overflowing signed division.
    // A zero divisor is replaced by 1 to keep the datapath X-free; commit_ok
    // is then cleared so HI/LO stay untouched.
    function automatic logic [64:0] md_calc(input logic [1:0]  op_i,
                                            input logic [31:0] a_i,
                                            input logic [31:0] b_i);
        logic [63:0] prod;
        logic [31:0] abs_a, abs_b, den, q_mag, r_mag, q, r;
        logic        sa, sb;
        logic [64:0] res;
        prod  = 64'd0;
        res   = 65'd0;
        sa    = (op_i == 2'd2) & a_i[31];
        sb    = (op_i == 2'd2) & b_i[31];
        abs_a = sa ? (32'd0 - a_i) : a_i;
        abs_b = sb ? (32'd0 - b_i) : b_i;
        den   = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag = abs_a / den;
        r_mag = abs_a % den;
        q     = (sa ^ sb) ? (32'd0 - q_mag) : q_mag;
        r     = sa ? (32'd0 - r_mag) : r_mag;
        case (op_i)
            2'd0: begin
                prod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
                res  = {1'b1, prod};
            end
            2'd1: begin
                prod = {32'd0, a_i} * {32'd0, b_i};
                res  = {1'b1, prod};
            end
            2'd2, 2'd3: begin
                res = {(b_i != 32'd0), r, q};
            end
            default: begin
                res = 65'd0;
            end
        endcase
        return res;
    endfunction

    state_t             state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic               busy_r, done_r;
    logic [31:0]        hi_r, lo_r, hi_next_s, lo_next_s;
    logic [31:0]        pend_hi_r, pend_lo_r;
    logic               pend_ok_r;
    logic               capture_s, commit_s;
    logic [64:0]        calc_s;

    assign calc_s = md_calc(op, a, b);

    // Next-state, counter and HI/LO update selection.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        hi_next_s    = hi_r;
        lo_next_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // start wins over a coincident mthi/mtlo
                    next_state_s = RUN;
                    cnt_next_s   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = IDLE;
                    if (mthi) begin
                        hi_next_s = wdata;
                    end else begin
                        hi_next_s = hi_r;
                    end
                    if (mtlo) begin
                        lo_next_s = wdata;
                    end else begin
                        lo_next_s = lo_r;
                    end
                end
            end
            RUN: begin
                // start/mthi/mtlo are ignored while running
                if (cnt_r == CNT_W'(1)) begin
                    next_state_s = IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                    commit_s     = 1'b1;
                    if (pend_ok_r) begin
                        hi_next_s = pend_hi_r;
                        lo_next_s = pend_lo_r;
                    end else begin
                        hi_next_s = hi_r;
                        lo_next_s = lo_r;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_ok_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (next_state_s == RUN);
            done_r  <= commit_s;
            hi_r    <= hi_next_s;
            lo_r    <= lo_next_s;
            if (capture_s) begin
                pend_hi_r <= calc_s[63:32];
                pend_lo_r <= calc_s[31:0];
                pend_ok_r <= calc_s[64];
            end else begin
                pend_hi_r <= pend_hi_r;
                pend_lo_r <= pend_lo_r;
                pend_ok_r <= pend_ok_r;
            end
        end
    end

    // start counts on its own cycle so the D-stage op is blocked immediately.
    assign stall = md_d & (start | busy_r);
    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    localparam int MULT_K = 5;
    localparam int DIV_K  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
    logic        mthi = 1'b0, mtlo = 1'b0, md_d = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    mdu_ctrl #(.MULT_CYCLES(MULT_K), .DIV_CYCLES(DIV_K), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .md_d(md_d),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    // Architectural model
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic in plain 64-bit integer terms.
    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic ok, output logic [31:0] rh, output logic [31:0] rl);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        ok = 1'b1; rh = 32'd0; rl = 32'd0;
        case (o)
            2'd0: begin q = sx * sy; rh = q[63:32]; rl = q[31:0]; end
            2'd1: begin uq = ux * uy; rh = uq[63:32]; rl = uq[31:0]; end
            2'd2: begin
                if (y == 32'd0) ok = 1'b0;
                else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            end
            default: begin
                if (y == 32'd0) ok = 1'b0;
                else begin uq = ux / uy; ur = ux % uy; rl = uq[31:0]; rh = ur[31:0]; end
            end
        endcase
    endfunction

    // One clock of stimulus: check state, drive inputs, check stall, advance model.
    task automatic step(input logic s, input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic mh, input logic ml, input logic [31:0] wd, input logic md);
        logic        ok;
        logic [31:0] rh, rl;
        exp_t        e;
        int          k;
        @(negedge clk);
        check("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        start = s; op = o; a = aa; b = bb; mthi = mh; mtlo = ml; wdata = wd; md_d = md;
        #1;
        check("stall", {31'd0, stall}, {31'd0, md & (s | (m_left != 0))});
        if (m_left == 0 && s) begin
            ref_calc(o, aa, bb, ok, rh, rl);
            k = o[1] ? DIV_K : MULT_K;
            e.hi = ok ? rh : m_hi;
            e.lo = ok ? rl : m_lo;
            e.cyc = cyc + 1 + k;
            sb_q.push_back(e);
            p_hi = e.hi; p_lo = e.lo;
            m_left = k;
        end else if (m_left == 0) begin
            if (mh) m_hi = wd;
            if (ml) m_lo = wd;
        end else begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end
    endtask

    task automatic idle(input int n, input logic md = 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, md);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; md_d = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (done && !reset) begin
            if (sb_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_hi", hi, e.hi);
                check("done_lo", lo, e.lo);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        // reset state
        @(negedge clk);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_done", {31'd0, done}, 32'd0);
        check("init_hi", hi, 32'd0);
        check("init_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // reset mid-run abandons the op
        step(1'b1, 2'd0, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(1);
        do_reset();
        idle(8);

        // mult / multu of -2 * 3
        step(1'b1, 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(MULT_K + 1);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFA);
        step(1'b1, 2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(MULT_K + 1);
        check("multu_hi_const", hi, 32'h0000_0002);
        check("multu_lo_const", lo, 32'hFFFF_FFFA);

        // div -7/2, then divu by zero keeps HI/LO
        step(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(DIV_K + 1);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        step(1'b1, 2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(DIV_K + 1);
        check("div0_lo_const", lo, 32'hFFFF_FFFD);

        // signed overflow case
        step(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(DIV_K + 1);
        check("ovf_lo_const", lo, 32'h8000_0000);
        check("ovf_hi_const", hi, 32'h0000_0000);

        // stall window with md_d held high, then low
        step(1'b1, 2'd0, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 1'b1);
        idle(MULT_K + 2, 1'b1);
        step(1'b1, 2'd1, 32'd4, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(MULT_K + 2, 1'b0);

        // moves: idle mthi, mtlo during busy, mtlo coincident with start
        step(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        idle(1);
        check("mthi_const", hi, 32'h1234_5678);
        step(1'b1, 2'd0, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle(MULT_K);
        step(1'b1, 2'd1, 32'd6, 32'd7, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        idle(MULT_K + 1);
        check("mtlo_drop_const", lo, 32'd42);

        // second start during busy is ignored
        step(1'b1, 2'd0, 32'd10, 32'd10, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 2'd2, 32'd99, 32'd3, 1'b1, 1'b1, 32'h5555_5555, 1'b1);
        idle(MULT_K + 1);
        check("restart_lo_const", lo, 32'd100);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic s;
            s = ($urandom_range(0, 3) == 0);
            step(s, 2'($urandom_range(0, 3)), pick(), pick(),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 32'($urandom), 1'($urandom_range(0, 1)));
        end

        idle(DIV_K + 3);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
